// File: rtl/permutation_arbiter.sv
// Two-requester round-robin arbiter in front of a single Permutation engine.
// Optional watchdog abort of stalled transactions: define PERM_ARB_TIMEOUT_EN.
module permutation_arbiter #(
  parameter int N             = 5,
  parameter int Count         = 64,
  parameter int TimeoutCycles = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [N*N-1:0]   matrixIn0,
  input  logic [N*N-1:0]   matrixIn1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             putInput0,
  output logic             putInput1,
  output logic             done0,
  output logic             done1,
  output logic [N*N-1:0]   matrixOut,
  output logic             err,
  output logic             permStart,
  output logic [N*N-1:0]   permMatrixIn,
  input  logic             permReady,
  input  logic             permPutInput,
  input  logic [N*N-1:0]   permMatrixOut
);

  // state     | meaning
  // IDLE      | no grant; arbitrate on next edge
  // START     | grant set, engine start pulse, slice counter cleared
  // WAIT_BUSY | waiting for the engine to drop permReady
  // BUSY      | engine running; waiting for permReady
  // DONE      | done pulse to granted requester; grant released next edge
  localparam int CW = $clog2(Count) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT_BUSY, S_BUSY, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      gnt_q, gnt_d;
  logic            last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;

`ifdef PERM_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TimeoutCycles) + 1;
  logic [WW-1:0]   wd_q, wd_d;
`else
  logic            unused_timeout_cfg;
  assign unused_timeout_cfg = (TimeoutCycles == 0);
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
`ifdef PERM_ARB_TIMEOUT_EN
    wd_d    = wd_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          state_d = S_START;
          if (req0 && req1) gnt_d = last_q ? 2'b01 : 2'b10;
          else              gnt_d = req0 ? 2'b01 : 2'b10;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: if (!permReady) state_d = S_BUSY;
      S_BUSY:      if (permReady)  state_d = S_DONE;
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = 2'b00;
        last_d  = gnt_q[1];
        if (cnt_q != CW'(Count)) err_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Saturate so an over-long transaction can never wrap back to Count.
    if ((state_q == S_WAIT_BUSY || state_q == S_BUSY) && permPutInput && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;

`ifdef PERM_ARB_TIMEOUT_EN
    if (state_q == S_START) wd_d = '0;
    if (state_q == S_WAIT_BUSY || state_q == S_BUSY) begin
      if (wd_q == WW'(TimeoutCycles - 1)) begin
        state_d = S_IDLE;
        gnt_d   = 2'b00;
        err_d   = 1'b1;
        last_d  = gnt_q[1];
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= 2'b00;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef PERM_ARB_TIMEOUT_EN
      wd_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef PERM_ARB_TIMEOUT_EN
      wd_q    <= wd_d;
`endif
    end
  end

  assign gnt0         = gnt_q[0];
  assign gnt1         = gnt_q[1];
  assign done0        = (state_q == S_DONE) && gnt_q[0];
  assign done1        = (state_q == S_DONE) && gnt_q[1];
  assign permStart    = (state_q == S_START);
  assign putInput0    = permPutInput && gnt_q[0];
  assign putInput1    = permPutInput && gnt_q[1];
  assign matrixOut    = permMatrixOut;
  assign err          = err_q;
  assign permMatrixIn = gnt_q[0] ? matrixIn0 : (gnt_q[1] ? matrixIn1 : '0);

endmodule

// File: tb/tb_permutation_arbiter.sv
// Scoreboard bench for permutation_arbiter: a driver acts as both requesters and the
// engine, pushing the expected done index / err value; a monitor checks each done pulse.
module tb_permutation_arbiter;
  localparam int NN = 25;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1;
  logic [NN-1:0] matrixIn0, matrixIn1;
  logic          gnt0, gnt1, putInput0, putInput1, done0, done1, err, permStart;
  logic [NN-1:0] matrixOut, permMatrixIn;
  logic          permReady, permPutInput;
  logic [NN-1:0] permMatrixOut;

  typedef struct { int idx; int err; } exp_t;
  exp_t exp_q[$];

  int pass_cnt = 0;
  int total_cnt = 0;
  bit overlap = 1'b0;

  always #5 clk = ~clk;

  permutation_arbiter #(.N(5), .Count(64), .TimeoutCycles(256)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .matrixIn0(matrixIn0), .matrixIn1(matrixIn1),
    .gnt0(gnt0), .gnt1(gnt1), .putInput0(putInput0), .putInput1(putInput1),
    .done0(done0), .done1(done1), .matrixOut(matrixOut), .err(err),
    .permStart(permStart), .permMatrixIn(permMatrixIn),
    .permReady(permReady), .permPutInput(permPutInput), .permMatrixOut(permMatrixOut)
  );

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(negedge clk) if (gnt0 && gnt1) overlap = 1'b1;

  // Monitor: every done pulse must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (done0 || done1)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", {30'd0, done1, done0}, 0);
        end else begin
          e = exp_q.pop_front();
          check("done_vec", {30'd0, done1, done0}, (e.idx == 1) ? 2 : 1);
          @(negedge clk);
          check("done_width", {30'd0, done1, done0}, 0);
          check("gnt_after_done", {30'd0, gnt1, gnt0}, 0);
          check("err_after_done", int'(err), e.err);
        end
      end
    end
  end

  // Engine model plus grant checks for one transaction; returns negedges waited for permStart.
  task automatic serve(input int pulses, input int who, input bit drop_req, output int waits);
    logic [1:0]    exp_g;
    logic [NN-1:0] pat, exp_in;
    bit ok;
    exp_g  = (who == 1) ? 2'b10 : 2'b01;
    exp_in = (who == 1) ? matrixIn1 : matrixIn0;
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (!permStart && waits < 12);
    check("start_seen", int'(permStart), 1);
    check("grant_vec", int'({gnt1, gnt0}), int'(exp_g));
    if (drop_req) begin
      if (who == 1) req1 = 1'b0; else req0 = 1'b0;
    end
    permReady = 1'b0;
    @(negedge clk);
    check("start_one_cycle", int'(permStart), 0);
    ok = 1'b1;
    for (int p = 0; p < pulses; p++) begin
      pat = NN'(p * 40503 + 17);
      permPutInput = 1'b1;
      permMatrixOut = pat;
      #1;
      if ({putInput1, putInput0} != exp_g || matrixOut != pat || permMatrixIn != exp_in) ok = 1'b0;
      @(negedge clk);
    end
    permPutInput = 1'b0;
    permReady = 1'b1;
    check("datapath_steer", int'(ok), 1);
  endtask

  initial begin
    int w, cyc;
    exp_t e;
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    int w;
    int cyc;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    matrixIn0 = 25'h0ABCDEF; matrixIn1 = 25'h1234567;
    permReady = 1'b1; permPutInput = 1'b1; permMatrixOut = '0;
    repeat (3) @(negedge clk);
    check("rst_gnt", int'({gnt1, gnt0}), 0);
    check("rst_done", int'({done1, done0}), 0);
    check("rst_start", int'(permStart), 0);
    check("rst_err", int'(err), 0);
    check("rst_pmin", int'(permMatrixIn), 0);
    check("rst_putinput_gated", int'({putInput1, putInput0}), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_putinput_gated", int'({putInput1, putInput0}), 0);
    permPutInput = 1'b0;

    // single request
    req0 = 1'b1;
    exp_q.push_back('{0, 0});
    serve(64, 0, 1'b0, w);
    check("start_latency", w, 1);
    @(negedge clk); req0 = 1'b0;
    repeat (2) @(negedge clk);

    // contention from reset: 0,1,0
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    exp_q.push_back('{0, 0}); exp_q.push_back('{1, 0}); exp_q.push_back('{0, 0});
    serve(64, 0, 1'b0, w);
    serve(64, 1, 1'b0, w);
    serve(64, 0, 1'b0, w);
    @(negedge clk); req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);

    // short transaction, then sticky err across a good one
    req0 = 1'b1;
    exp_q.push_back('{0, 1});
    serve(63, 0, 1'b0, w);
    @(negedge clk); req0 = 1'b0;
    repeat (2) @(negedge clk);
    req1 = 1'b1;
    exp_q.push_back('{1, 1});
    serve(64, 1, 1'b0, w);
    @(negedge clk); req1 = 1'b0;
    repeat (2) @(negedge clk);
    check("err_sticky", int'(err), 1);

    // reset during BUSY
    req1 = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!permStart && cyc < 12);
    permReady = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_gnt", int'({gnt1, gnt0}), 0);
    check("midrst_done_start", int'({done1, done0, permStart}), 0);
    check("midrst_err", int'(err), 0);
    check("midrst_pmin", int'(permMatrixIn), 0);
    @(negedge clk);
    rst = 1'b0; permReady = 1'b1;
    exp_q.push_back('{1, 0});
    serve(64, 1, 1'b0, w);
    check("post_rst_latency", w, 1);
    @(negedge clk); req1 = 1'b0;
    repeat (2) @(negedge clk);

    // request dropped right after START
    req1 = 1'b1;
    exp_q.push_back('{1, 0});
    serve(64, 1, 1'b1, w);
    repeat (3) @(negedge clk);
    check("drop_no_regrant", int'({gnt1, gnt0}), 0);

`ifdef PERM_ARB_TIMEOUT_EN
    // stalled engine: lastGrant is 1, so requester 0 is aborted, then 1 is granted
    req0 = 1'b1; req1 = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!permStart && cyc < 12);
    check("to_grant", int'({gnt1, gnt0}), 1);
    permReady = 1'b0;
    cyc = 1;
    while (gnt0 && cyc < 400) begin
      @(negedge clk);
      if (gnt0) cyc++;
    end
    check("to_grant_cycles", cyc, 257);
    check("to_err", int'(err), 1);
    permReady = 1'b1;
    exp_q.push_back('{1, 1});
    serve(64, 1, 1'b0, w);
    @(negedge clk); req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    check("grant_exclusive", int'(overlap), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/permutation_arbiter.md
# permutation_arbiter

Round-robin arbiter that shares one Permutation engine (N×N-bit slice datapath, Count slices per transaction) between two requesters. It grants the engine to one requester at a time, issues the engine start pulse, and steers that requester's slice input to the engine. It returns the engine's slice requests and result slices to the granted requester and signals completion with a one-cycle done pulse. It sits between the two slice producers of the hash core and the single Permutation instance.

## Interface
- N, 5, matrix dimension; slice width is N*N bits
- Count, 64, slices per transaction; sets the putInput pulses expected per transaction
- TimeoutCycles, 256, BUSY-cycle limit; used only with PERM_ARB_TIMEOUT_EN

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req0, req1  in  1  level request; the requester holds it until its done pulse
- matrixIn0, matrixIn1  in  N*N  requester slice data
- gnt0, gnt1  out  1  registered grant; at most one is high
- putInput0, putInput1  out  1  engine putInput gated by the matching gnt
- done0, done1  out  1  one-cycle completion pulse
- matrixOut  out  N*N  engine result, broadcast; valid for the granted requester
- err  out  1  sticky protocol-error flag; cleared only by rst
- permStart  out  1  engine start pulse
- permMatrixIn  out  N*N  matrixIn of the granted requester; zero when no grant
- permReady  in  1  engine idle/finished indicator
- permPutInput  in  1  engine slice-request strobe
- permMatrixOut  in  N*N  engine result slice

## Operation
- The FSM has five states:
  - IDLE
  - START: permStart=1, the grant is set
  - WAIT_BUSY: waits for permReady=0
  - BUSY: waits for permReady=1
  - DONE: done_i=1, the grant is still held
- IDLE → START when any req is high at the clock edge. Selection:
  - only one requester active: grant it
  - both active: grant the one not recorded in lastGrant
  - lastGrant resets to 1, so req0 wins the first contention
- START → WAIT_BUSY unconditionally. WAIT_BUSY → BUSY when permReady=0. BUSY → DONE when permReady=1. DONE → IDLE unconditionally; lastGrant is updated to the granted index.
- The slice counter has log2(Count)+1 bits.
  - It clears in START.
  - It increments on each permPutInput in WAIT_BUSY or BUSY, saturating at its maximum.
- In DONE, if the counter ≠ Count, err is set.
- Dropping req mid-transaction is ignored; the transaction runs to DONE and done still pulses.
- permPutInput while no grant is held is ignored and does not set err.
- permMatrixIn, putInput_i and matrixOut are combinational from the grant registers and the engine signals.
- Reset mid-operation:
  - all outputs deassert immediately
  - FSM goes to IDLE, lastGrant=1, counter=0, err=0
  - the engine is not notified and must share rst

## Timing
- Reset values: gnt0, gnt1, done0, done1, permStart and err are 0; permMatrixIn=0; putInput0/1=0.
- req_i is sampled at edge k; from k+1 the FSM is in START with gnt_i=1 and permStart=1 for exactly one cycle.
- The engine drops permReady by the next edge; WAIT_BUSY normally lasts one cycle.
- done_i is high in the cycle after permReady is seen high in BUSY; gnt_i drops one cycle after done_i.
- Back-to-back transactions: minimum 2 idle cycles (DONE, IDLE) between successive permStart pulses.
- A simultaneous new req and done on the same cycle is evaluated in the following IDLE cycle.

## Configuration
- PERM_ARB_TIMEOUT_EN defined:
  - a watchdog counts cycles spent in WAIT_BUSY+BUSY
  - reaching TimeoutCycles sets err, drops the grant, returns the FSM to IDLE without a done pulse, and sets lastGrant to the aborted requester
- PERM_ARB_TIMEOUT_EN undefined: no watchdog; the FSM waits indefinitely for permReady.

## Test plan
- Single request: hold req0=1; the engine model asserts 64 putInput pulses and then ready.
  - Expect gnt0 and permStart on the cycle after req0.
  - Expect permMatrixIn=matrixIn0 throughout.
  - Expect done0 for one cycle and err=0.
- Contention: req0=req1=1 from reset.
  - Expect transaction order 0, 1, 0 over three transactions.
  - Expect gnt0 and gnt1 never high together.
- Short transaction: the engine model gives 63 putInput pulses. Expect done0 still pulses and err=1, remaining 1 until rst.
- Mid-operation reset: assert rst during BUSY. Expect gnt, done and permStart at 0 at once, and after release a new req1 granted normally.
- Request drop: deassert req1 after START. Expect the transaction to complete and done1 to pulse.
- Timeout, with PERM_ARB_TIMEOUT_EN and TimeoutCycles=256: hold permReady=0 forever. Expect the grant to drop after 256 busy cycles, err=1, no done pulse, and the other requester granted next.
